// File: rtl/otter_ctrl_pkg.sv
// rtl/otter_ctrl_pkg.sv - shared PC-source and redirect-state types for the OTTER control path
package otter_ctrl_pkg;

    typedef enum logic [2:0] {
        PC_PLUS4 = 3'b000,
        JALR     = 3'b001,
        BRANCH   = 3'b010,
        JAL      = 3'b011,
        INTR     = 3'b100,
        MRET     = 3'b101
    } pc_src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        BUBBLE = 2'd2
    } redir_state_t;

    // Only these sources are sequenced here; JAL/JALR resolve earlier in the pipe.
    function automatic logic is_redir_src(input logic [2:0] src);
        return (src == BRANCH) || (src == INTR) || (src == MRET);
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - EX-stage branch resolution in, PC mux/hold/flush controls out
interface pc_redirect_ctrl_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        br_taken;
    logic [2:0]  br_src;
    logic [31:0] br_target;
    logic        icache_busy;
    logic [2:0]  pc_sel;
    logic [31:0] pc_target;
    logic        pc_hold;
    logic        flush;
    logic        intr_ack;
    logic        mepc_we;
    logic [31:0] mepc_val;

    modport master (
        output ex_valid, ex_pc, br_taken, br_src, br_target, icache_busy,
        input  pc_sel, pc_target, pc_hold, flush, intr_ack, mepc_we, mepc_val
    );

    modport slave (
        input  ex_valid, ex_pc, br_taken, br_src, br_target, icache_busy,
        output pc_sel, pc_target, pc_hold, flush, intr_ack, mepc_we, mepc_val
    );
endinterface

// File: rtl/redir_sat_cnt.sv
// rtl/redir_sat_cnt.sv - saturating performance counter with synchronous clear priority
module redir_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - redirect sequencer: applies, defers or suppresses EX-stage PC redirects
module pc_redirect_ctrl
    import otter_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    pc_redirect_ctrl_if.slave  bus,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   redir_cnt
);

    localparam redir_state_t AFTER_APPLY = (FLUSH_CYCLES > 1) ? BUBBLE : IDLE;
    localparam logic [2:0]   BUB_LOAD    = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    redir_state_t state_q, state_d;
    logic [2:0]   pend_src_q, pend_src_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;
    logic [2:0]   bub_q, bub_d;
    logic         accept;

    assign accept = (state_q == IDLE) && bus.ex_valid && bus.br_taken && is_redir_src(bus.br_src);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            pend_src_q <= '0;
            pend_tgt_q <= '0;
            bub_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
            bub_q      <= bub_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_src_d    = pend_src_q;
        pend_tgt_d    = pend_tgt_q;
        bub_d         = bub_q;
        bus.pc_sel    = PC_PLUS4;
        bus.pc_target = '0;
        bus.pc_hold   = bus.icache_busy;
        bus.flush     = 1'b0;
        bus.intr_ack  = 1'b0;
        bus.mepc_we   = 1'b0;
        bus.mepc_val  = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    bus.flush = 1'b1;
                    if (bus.br_src == INTR) begin
                        bus.intr_ack = 1'b1;
                        bus.mepc_we  = 1'b1;
                        bus.mepc_val = bus.ex_pc;
                    end
                    if (bus.icache_busy) begin
                        bus.pc_hold = 1'b1;
                        pend_src_d  = bus.br_src;
                        pend_tgt_d  = bus.br_target;
                        state_d     = PEND;
                    end else begin
                        bus.pc_sel    = bus.br_src;
                        bus.pc_target = bus.br_target;
                        bub_d         = BUB_LOAD;
                        state_d       = AFTER_APPLY;
                    end
                end
            end
            // Outputs here depend only on latched state and icache_busy, never on br_*.
            PEND: begin
                bus.pc_hold = 1'b1;
                bus.flush   = 1'b1;
                if (!bus.icache_busy) begin
                    bus.pc_sel    = pend_src_q;
                    bus.pc_target = pend_tgt_q;
                    bus.pc_hold   = 1'b0;
                    bub_d         = BUB_LOAD;
                    state_d       = AFTER_APPLY;
                end
            end
            BUBBLE: begin
                bus.flush = 1'b1;
                if (bub_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    bub_d = bub_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Keep the combinational redirect path quiet while reset is held.
        if (!RST_N) begin
            bus.pc_sel    = PC_PLUS4;
            bus.pc_target = '0;
            bus.pc_hold   = 1'b0;
            bus.flush     = 1'b0;
            bus.intr_ack  = 1'b0;
            bus.mepc_we   = 1'b0;
            bus.mepc_val  = '0;
        end
    end

    redir_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (accept),
        .clr   (cnt_clr),
        .cnt   (redir_cnt)
    );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - scoreboard bench for pc_redirect_ctrl against a cycle-count reference model
module tb_pc_redirect_ctrl;

    localparam int FLUSH = 2;
    localparam int CW    = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] redir_cnt;

    always #5 CLK = ~CLK;

    pc_redirect_ctrl_if bus();

    pc_redirect_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(CW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .redir_cnt (redir_cnt)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] tgt;
        logic        hold;
        logic        flush;
        logic        ack;
        logic        we;
        logic [31:0] mepc;
        logic [31:0] cnt;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    // Reference model: pending flag, remaining flush cycles, plain integer counter.
    bit          m_pend;
    int          m_left;
    logic [2:0]  m_psrc;
    logic [31:0] m_ptgt;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_left = 0;
        m_psrc = '0;
        m_ptgt = '0;
        m_cnt  = 0;
    endtask

    task automatic set_idle(input logic busy);
        bus.ex_valid    = 1'b0;
        bus.ex_pc       = '0;
        bus.br_taken    = 1'b0;
        bus.br_src      = '0;
        bus.br_target   = '0;
        bus.icache_busy = busy;
        cnt_clr         = 1'b0;
    endtask

    task automatic step(input logic ev, input logic [31:0] pc, input logic bt, input logic [2:0] src,
                        input logic [31:0] tgt, input logic busy, input logic clr);
        exp_t e;
        bit   acc;
        @(posedge CLK);
        #1;
        bus.ex_valid    = ev;
        bus.ex_pc       = pc;
        bus.br_taken    = bt;
        bus.br_src      = src;
        bus.br_target   = tgt;
        bus.icache_busy = busy;
        cnt_clr         = clr;

        e.sel = '0; e.tgt = '0; e.hold = busy; e.flush = 1'b0;
        e.ack = 1'b0; e.we = 1'b0; e.mepc = '0; e.cnt = 32'(m_cnt);
        acc = 0;
        if (m_pend) begin
            e.hold  = 1'b1;
            e.flush = 1'b1;
            if (!busy) begin
                e.sel  = m_psrc;
                e.tgt  = m_ptgt;
                e.hold = 1'b0;
                m_pend = 0;
                m_left = FLUSH - 1;
            end
        end else if (m_left > 0) begin
            e.flush = 1'b1;
            m_left--;
        end else if (ev && bt && (src == 3'd2 || src == 3'd4 || src == 3'd5)) begin
            acc     = 1;
            e.flush = 1'b1;
            if (src == 3'd4) begin
                e.ack  = 1'b1;
                e.we   = 1'b1;
                e.mepc = pc;
            end
            if (busy) begin
                e.hold = 1'b1;
                m_pend = 1;
                m_psrc = src;
                m_ptgt = tgt;
            end else begin
                e.sel  = src;
                e.tgt  = tgt;
                m_left = FLUSH - 1;
            end
        end
        if (clr) m_cnt = 0;
        else if (acc && m_cnt < (1 << CW) - 1) m_cnt++;
        expq.push_back(e);
    endtask

    task automatic idle(input logic busy);
        step(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, busy, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_pc_sel",    32'(bus.pc_sel), 0);
        chk("rst_pc_target", bus.pc_target, 0);
        chk("rst_pc_hold",   32'(bus.pc_hold), 0);
        chk("rst_flush",     32'(bus.flush), 0);
        chk("rst_intr_ack",  32'(bus.intr_ack), 0);
        chk("rst_mepc_we",   32'(bus.mepc_we), 0);
        chk("rst_mepc_val",  bus.mepc_val, 0);
        chk("rst_redir_cnt", 32'(redir_cnt), 0);
    endtask

    always @(negedge CLK) begin
        if (RST_N && expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("pc_sel",    32'(bus.pc_sel),   32'(mon_e.sel));
            chk("pc_target", bus.pc_target,     mon_e.tgt);
            chk("pc_hold",   32'(bus.pc_hold),  32'(mon_e.hold));
            chk("flush",     32'(bus.flush),    32'(mon_e.flush));
            chk("intr_ack",  32'(bus.intr_ack), 32'(mon_e.ack));
            chk("mepc_we",   32'(bus.mepc_we),  32'(mon_e.we));
            chk("mepc_val",  bus.mepc_val,      mon_e.mepc);
            chk("redir_cnt", 32'(redir_cnt),    mon_e.cnt);
        end
    end

    initial begin
        logic busy_r;
        model_reset();
        bus.ex_valid = 1'b1; bus.ex_pc = 32'h40; bus.br_taken = 1'b1;
        bus.br_src = 3'd2; bus.br_target = 32'h80; bus.icache_busy = 1'b0;
        #3;
        chk_reset_outputs();
        set_idle(1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST_N = 1'b1;

        // immediate branch redirect
        step(1'b1, 32'h10, 1'b1, 3'd2, 32'h100, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // deferred redirect, busy for three cycles
        step(1'b1, 32'h14, 1'b1, 3'd2, 32'h100, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        // interrupt acknowledge
        step(1'b1, 32'h44, 1'b1, 3'd4, 32'h200, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // wrong-path requests in BUBBLE and in PEND
        step(1'b1, 32'h50, 1'b1, 3'd2, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h54, 1'b1, 3'd4, 32'h400, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 32'h60, 1'b1, 3'd5, 32'h500, 1'b1, 1'b0);
        step(1'b1, 32'h64, 1'b1, 3'd2, 32'h600, 1'b1, 1'b0);
        step(1'b1, 32'h68, 1'b1, 3'd4, 32'h700, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // reset while PEND discards the pending redirect
        step(1'b1, 32'h70, 1'b1, 3'd2, 32'h800, 1'b1, 1'b0);
        idle(1'b1);
        @(negedge CLK);
        #2;
        bus.ex_valid = 1'b1; bus.br_taken = 1'b1; bus.br_src = 3'd2;
        bus.br_target = 32'h900; bus.icache_busy = 1'b1;
        RST_N = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        set_idle(1'b1);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        idle(1'b0);
        idle(1'b0);

        // saturation at 4 bits, then clear beating a simultaneous acceptance
        step(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 32'(i * 4), 1'b1, 3'd2, $urandom, 1'b0, 1'b0);
            idle(1'b0);
        end
        idle(1'b0);
        step(1'b1, 32'h90, 1'b1, 3'd5, 32'ha00, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // randomized traffic
        busy_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) busy_r = ~busy_r;
            step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)), $urandom, busy_r, ($urandom_range(0, 49) == 0));
        end

        @(negedge CLK);
        #2;
        chk("queue_drained", 32'(expq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
